avg_frame_ctrl: RTL and testbench



---
 rtl/avg_frame_if.sv | 34 +++
 rtl/avg_frame_ctrl.sv | 105 ++++++++++
 tb/tb_avg_frame_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/avg_frame_if.sv
// Stream, frame-RAM and status signals of the vertical row-averaging sequencer.
// The master modport is the controller side; the slave modport is its environment.
interface avg_frame_if #(
  parameter int AW = 7
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr_a;
  logic [AW-1:0] mem_raddr_b;
  logic [7:0]    mem_rdata_a;
  logic [7:0]    mem_rdata_b;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          busy;
  logic          frame_done;

  modport master (
    input  in_valid, in_data, mem_rdata_a, mem_rdata_b, out_ready,
    output in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr_a, mem_raddr_b,
    output out_valid, out_data, busy, frame_done
  );

  modport slave (
    output in_valid, in_data, mem_rdata_a, mem_rdata_b, out_ready,
    input  in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr_a, mem_raddr_b,
    input  out_valid, out_data, busy, frame_done
  );
endinterface

// File: rtl/avg_frame_ctrl.sv
// Loads one ROWSxCOLS frame into external RAM, then streams averages of vertically adjacent pixels.
// Define AVG_FRAME_ROUND_EN for round-half-up averaging; default truncates.
module avg_frame_ctrl #(
  parameter int ROWS = 16,
  parameter int COLS = 8,
  parameter int AW   = 7
) (
  input  logic       clk,
  input  logic       reset,
  avg_frame_if.master bus
);

  localparam int NPIX = ROWS * COLS;
  localparam int NOUT = (ROWS - 1) * COLS;
  localparam int CW   = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_wr_cnt;
  logic [CW-1:0]   r_rd_cnt;
  logic [CW-1:0]   w_raddr_b;
  logic            r_out_valid;
  logic            w_in_ready;
  logic            w_we;
  logic            w_re;
  logic            w_hs;

  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
`ifdef AVG_FRAME_ROUND_EN
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
`else
    sum = {1'b0, a} + {1'b0, b};
`endif
    return sum[8:1];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_hs        = r_out_valid & bus.out_ready;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_we       = bus.in_valid;
        if (bus.in_valid) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_in_ready = 1'b1;
        w_we       = bus.in_valid;
        if (bus.in_valid && r_wr_cnt == CW'(NPIX - 1)) w_state_nxt = EMIT;
      end
      EMIT: begin
        // A new read may only replace RAM data once the pending output is taken.
        w_re = (r_rd_cnt < CW'(NOUT)) && (!r_out_valid || bus.out_ready);
        if (w_hs && r_rd_cnt == CW'(NOUT)) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == DONE) begin
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end else begin
        if (w_we) r_wr_cnt <= r_wr_cnt + CW'(1);
        if (w_re) r_rd_cnt <= r_rd_cnt + CW'(1);
      end
      if (w_re)      r_out_valid <= 1'b1;
      else if (w_hs) r_out_valid <= 1'b0;
    end
  end

  assign w_raddr_b       = r_rd_cnt + CW'(COLS);

  assign bus.in_ready    = w_in_ready;
  assign bus.mem_we      = w_we;
  assign bus.mem_waddr   = r_wr_cnt[AW-1:0];
  assign bus.mem_wdata   = bus.in_data;
  assign bus.mem_re      = w_re;
  assign bus.mem_raddr_a = r_rd_cnt[AW-1:0];
  assign bus.mem_raddr_b = w_raddr_b[AW-1:0];
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = avg2(bus.mem_rdata_a, bus.mem_rdata_b);
  assign bus.busy        = (r_state != IDLE);
  assign bus.frame_done  = (r_state == DONE);

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Directed bench for avg_frame_ctrl with a behavioural dual-read frame RAM.
module tb_avg_frame_ctrl;

  localparam int ROWS = 16;
  localparam int COLS = 8;
  localparam int AW   = 7;
  localparam int NPIX = ROWS * COLS;
  localparam int NOUT = (ROWS - 1) * COLS;
`ifdef AVG_FRAME_ROUND_EN
  localparam int ALT_EXP = 8'h80;
`else
  localparam int ALT_EXP = 8'h7F;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] ram [NPIX];
  logic [7:0] p   [NPIX];

  avg_frame_if #(.AW(AW)) bus ();

  avg_frame_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re) begin
      bus.mem_rdata_a <= ram[bus.mem_raddr_a];
      bus.mem_rdata_b <= ram[bus.mem_raddr_b];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_px(input int mode, input int k);
    case (mode)
      0:       return k + 4;
      1:       return ALT_EXP;
      2:       return 8'hFF;
      default: return (int'(p[k]) + int'(p[k+COLS])
`ifdef AVG_FRAME_ROUND_EN
                       + 1
`endif
                      ) / 2;
    endcase
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < NPIX; k++) begin
      case (mode)
        0:       p[k] = 8'(k);
        1:       p[k] = ((k / COLS) % 2 == 1) ? 8'hFF : 8'h00;
        2:       p[k] = 8'hFF;
        default: p[k] = 8'($urandom_range(255));
      endcase
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ovld"}, bus.out_valid, 0);
    chk({tag, "_irdy"}, bus.in_ready, 1);
    chk({tag, "_fdone"}, bus.frame_done, 0);
    chk({tag, "_re"}, bus.mem_re, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk({tag, "_nofdone"}, bus.frame_done, 0);
      chk({tag, "_idle"}, bus.busy, 0);
      step();
    end
  endtask

  task automatic run_frame(input int mode, input int gap_pct, input bit rnd_rdy, input int stall_at,
                           input int abort_ld, input int abort_em, input bit junk);
    int k, cyc, got, iss, stall_n;
    bit held_v;
    logic [7:0] held_d;
    fill(mode);
    k = 0;
    cyc = 0;
    while (k < NPIX && cyc < 2000) begin
      cyc++;
      if (k == abort_ld) begin
        do_reset("ab_ld");
        return;
      end
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        #2;
        chk("we_gap", bus.mem_we, 0);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = p[k];
        #2;
        chk("ld_rdy", bus.in_ready, 1);
        chk("ld_we", bus.mem_we, 1);
        chk("ld_addr", bus.mem_waddr, k);
        k++;
      end
      step();
    end
    chk("n_wr", k, NPIX);
    got = 0;
    iss = 0;
    cyc = 0;
    stall_n = 0;
    held_v = 1'b0;
    held_d = '0;
    while (got < NOUT && cyc < 3000) begin
      cyc++;
      if (got == abort_em) begin
        do_reset("ab_em");
        return;
      end
      if (stall_at >= 0 && got >= stall_at && stall_n < 10) begin
        bus.out_ready = 1'b0;
        stall_n++;
      end else begin
        bus.out_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
      end
      bus.in_valid = junk;
      bus.in_data  = 8'hAA;
      #2;
      chk("em_irdy", bus.in_ready, 0);
      chk("em_we", bus.mem_we, 0);
      chk("em_fdone", bus.frame_done, 0);
      if (cyc == 2) chk("latency", bus.out_valid, 1);
      if (held_v) begin
        chk("stall_vld", bus.out_valid, 1);
        chk("stall_data", bus.out_data, held_d);
      end
      if (bus.mem_re) begin
        chk("raddr_a", bus.mem_raddr_a, iss);
        chk("raddr_b", bus.mem_raddr_b, iss + COLS);
        iss++;
      end
      held_v = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        chk("re_stall", bus.mem_re, 0);
        held_v = 1'b1;
        held_d = bus.out_data;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_data", bus.out_data, exp_px(mode, got));
        got++;
      end
      step();
    end
    chk("n_out", got, NOUT);
    chk("n_iss", iss, NOUT);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("done_pulse", bus.frame_done, 1);
    chk("done_busy", bus.busy, 1);
    chk("done_ovld", bus.out_valid, 0);
    chk("done_irdy", bus.in_ready, 0);
    step();
    #2;
    chk("post_fdone", bus.frame_done, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_irdy", bus.in_ready, 1);
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovld", bus.out_valid, 0);
    chk("rst_fdone", bus.frame_done, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_irdy", bus.in_ready, 1);
    reset = 1'b1;
    step();

    run_frame(0, 0, 1'b0, -1, -1, -1, 1'b0);
    run_frame(1, 0, 1'b0, -1, -1, -1, 1'b0);
    run_frame(2, 0, 1'b0, -1, -1, -1, 1'b0);
    run_frame(3, 50, 1'b1, 30, -1, -1, 1'b0);
    run_frame(0, 0, 1'b0, -1, 60, -1, 1'b0);
    run_frame(0, 0, 1'b0, -1, -1, -1, 1'b0);
    run_frame(3, 0, 1'b0, -1, -1, 50, 1'b0);
    run_frame(3, 0, 1'b1, -1, -1, -1, 1'b1);
    run_frame(1, 20, 1'b1, 5, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
